// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one cache-line memory port (request side plus response side).
//
// Handshake: the requester raises read and/or write together with addr and
// wdata and holds all of them stable until it sees ready high for one cycle.
// ready is a single-cycle completion pulse; rdata is valid in that cycle.
// Dropping read/write before ready is an abort and is not a legal transfer.
//
// Modports:
//   master - drives read, write, addr, wdata; receives rdata, ready
//   slave  - receives read, write, addr, wdata; drives rdata, ready
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output read, write, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  read, write, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache and
// D-cache miss ports. One cache owns memory at a time, the grant is held
// until memory returns ready, and a one-cycle release bubble separates
// transactions. Ties are round-robin (D_PRIO=0) or always won by the
// D-cache (D_PRIO=1).
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   i_mem       - I-cache port (slave modport)
//   d_mem       - D-cache port (slave modport)
//   mem         - main-memory port (master modport)
//   owner       - 00 none, 01 I-cache, 10 D-cache
//   proto_err   - sticky protocol error (abort, or ready outside a grant)
//   state_dbg   - current FSM state encoding, for observation
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int D_PRIO = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_arbiter_if.slave         i_mem,
  mem_arbiter_if.slave         d_mem,
  mem_arbiter_if.master        mem,
  output logic [1:0]           owner,
  output logic                 proto_err,
  output logic [1:0]           state_dbg
);

  // Grant encodings equal the owner code, which keeps owner trivial.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam bit DP = (D_PRIO != 0);

  state_t state, state_nxt;
  logic   last_d, last_d_nxt;   // 1: D-cache owned the last transaction
  logic   err_set;
  logic   i_req, d_req;

  assign i_req = i_mem.read | i_mem.write;
  assign d_req = d_mem.read | d_mem.write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last_d    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      if (err_set) proto_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    err_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_req && d_req)
          // A tie goes to D when prioritised, else to whoever did not go last.
          state_nxt = (DP || !last_d) ? S_GRANT_D : S_GRANT_I;
        else if (d_req)
          state_nxt = S_GRANT_D;
        else if (i_req)
          state_nxt = S_GRANT_I;
        if (mem.ready) err_set = 1'b1;
      end
      S_GRANT_I: begin
        if (mem.ready) begin
          state_nxt  = S_RELEASE;
          last_d_nxt = 1'b0;
        end else if (!i_req) begin
          state_nxt  = S_RELEASE;
          last_d_nxt = 1'b0;
          err_set    = 1'b1;
        end
      end
      S_GRANT_D: begin
        if (mem.ready) begin
          state_nxt  = S_RELEASE;
          last_d_nxt = 1'b1;
        end else if (!d_req) begin
          state_nxt  = S_RELEASE;
          last_d_nxt = 1'b1;
          err_set    = 1'b1;
        end
      end
      S_RELEASE: begin
        // The last owner's request is ignored here, guaranteeing memory sees
        // at least one deasserted cycle. With D priority, a pending D request
        // sends us to IDLE where D wins the tie, so I only slips in from here
        // while D is quiet.
        if (last_d)
          state_nxt = (i_req && !(DP && d_req)) ? S_GRANT_I : S_IDLE;
        else
          state_nxt = d_req ? S_GRANT_D : S_IDLE;
        if (mem.ready) err_set = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Forwarding depends on state only for selection, so mem_ready never
  // reaches the memory request outputs combinationally.
  always_comb begin
    mem.read    = 1'b0;
    mem.write   = 1'b0;
    mem.addr    = '0;
    mem.wdata   = '0;
    i_mem.ready = 1'b0;
    d_mem.ready = 1'b0;
    case (state)
      S_GRANT_I: begin
        mem.read    = i_mem.read;
        mem.write   = i_mem.write;
        mem.addr    = i_mem.addr;
        mem.wdata   = i_mem.wdata;
        i_mem.ready = mem.ready;
      end
      S_GRANT_D: begin
        mem.read    = d_mem.read;
        mem.write   = d_mem.write;
        mem.addr    = d_mem.addr;
        mem.wdata   = d_mem.wdata;
        d_mem.ready = mem.ready;
      end
      default: ;
    endcase
  end

  assign i_mem.rdata = mem.rdata;
  assign d_mem.rdata = mem.rdata;

  assign owner     = (state == S_GRANT_I) ? 2'b01 :
                     (state == S_GRANT_D) ? 2'b10 : 2'b00;
  assign state_dbg = state;

endmodule
